// File: rtl/gemm_deskew_if.sv
`default_nettype none
// ============================================================================
// Module      : gemm_deskew_if
// Description : Bundle of the skewed systolic result lanes, the aligned-row
//               output handshake and the status outputs of gemm_deskew.
// Revision    : 1.0 - initial release
// ============================================================================
interface gemm_deskew_if #(
    parameter int N     = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) ();
    logic [N-1:0]                 in_valid;
    logic [N*DW-1:0]              in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [N*DW-1:0]              out_data;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         overflow;
    logic                         skew_err;

    // Producer/consumer side: feeds lanes, accepts rows, observes status
    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, count, overflow, skew_err
    );

    // Deskew block side
    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, count, overflow, skew_err
    );
endinterface
`default_nettype wire

// File: rtl/gemm_deskew.sv
`default_nettype none
// ============================================================================
// Module      : gemm_deskew
// Description : Realigns the diagonally skewed result lanes of a systolic
//               array into whole rows and buffers them in a small FIFO.
//               Lane i is delayed N-1-i cycles so all lanes of a row meet
//               at the alignment point; complete rows are pushed, partial
//               rows raise a sticky skew error, rows that find the FIFO
//               full raise a sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module gemm_deskew #(
    parameter int N     = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    gemm_deskew_if.slave  bus
);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);

    // Lanes as seen at the alignment point
    logic [N-1:0]    w_av;
    logic [N*DW-1:0] w_ad;

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        localparam int c_stages = N - 1 - gi;
        if (c_stages == 0) begin : g_pass
            // The last lane arrives already aligned
            assign w_av[gi]             = bus.in_valid[gi];
            assign w_ad[gi*DW +: DW]    = bus.in_data[gi*DW +: DW];
        end else begin : g_delay
            logic          r_v [c_stages];
            logic [DW-1:0] r_d [c_stages];

            // Valid shift chain; runs every cycle, there is no backpressure
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < c_stages; k++) r_v[k] <= 1'b0;
                end else begin
                    r_v[0] <= bus.in_valid[gi];
                    for (int k = 1; k < c_stages; k++) r_v[k] <= r_v[k-1];
                end
            end

            // Data shift chain, qualified by the valid chain so no reset
            always_ff @(posedge clk) begin
                r_d[0] <= bus.in_data[gi*DW +: DW];
                for (int k = 1; k < c_stages; k++) r_d[k] <= r_d[k-1];
            end

            assign w_av[gi]          = r_v[c_stages-1];
            assign w_ad[gi*DW +: DW] = r_d[c_stages-1];
        end
    end

    logic [N*DW-1:0]    r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;
    logic               r_skew_err;

    logic w_row;
    logic w_partial;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_row     = &w_av;
    assign w_partial = (|w_av) & ~w_row;
    assign w_pop     = (r_count != '0) & bus.out_ready;
    // A full FIFO still accepts a row when a slot frees up in the same cycle
    assign w_push    = w_row & ((r_count < c_full) | w_pop);
    assign w_drop    = w_row & ~w_push;

    // Row storage written at the write pointer
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_ad;
    end

    // Pointers, occupancy and sticky status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_skew_err <= 1'b0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == c_ptr_last) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == c_ptr_last) ? '0 : r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)    r_overflow <= 1'b1;
            if (w_partial) r_skew_err <= 1'b1;
        end
    end

    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = bus.out_valid ? r_mem[r_rptr] : '0;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.skew_err  = r_skew_err;
endmodule
`default_nettype wire
